// File: rtl/arc4_key_scheduler.sv
// ARC4 key-search dispatcher: walks an inclusive key range across NUM_CORES workers,
// stops on the first reported hit, and reports the winning key or "not found".
module arc4_key_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  output logic                       rdy,
  input  logic [KEY_W-1:0]           key_lo,
  input  logic [KEY_W-1:0]           key_hi,
  output logic                       found,
  output logic [KEY_W-1:0]           found_key,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_hit
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [KEY_W:0] KEY_ONE = {{KEY_W{1'b0}}, 1'b1};

  state_t               state_reg, state_next;
  logic [NUM_CORES-1:0] busy_reg, busy_next;
  // One extra bit so a range ending at all-ones terminates instead of wrapping.
  logic [KEY_W:0]       next_key_reg, next_key_next;
  logic [KEY_W-1:0]     key_hi_reg, key_hi_next;
  logic                 found_reg, found_next;
  logic [KEY_W-1:0]     found_key_reg, found_key_next;
  logic [KEY_W-1:0]     core_key_reg [NUM_CORES];

  logic [NUM_CORES-1:0] free_vec, hit_vec, first_free, start_vec;
  logic [KEY_W-1:0]     hit_key;
  logic                 hit_any, range_left;

  // A core that reports done this cycle is not restarted until the next one.
  assign free_vec   = ~busy_reg & ~core_done;
  assign hit_vec    = busy_reg & core_done & core_hit;
  assign hit_any    = |hit_vec;
  assign range_left = (next_key_reg <= {1'b0, key_hi_reg});

  // Descending scan so the lowest index is the one left standing.
  always_comb begin
    first_free = '0;
    hit_key    = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        first_free    = '0;
        first_free[i] = 1'b1;
      end
      if (hit_vec[i]) begin
        hit_key = core_key_reg[i];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    next_key_next  = next_key_reg;
    key_hi_next    = key_hi_reg;
    found_next     = found_reg;
    found_key_next = found_key_reg;
    start_vec      = '0;

    case (state_reg)
      IDLE, DONE: begin
        if (en) begin
          key_hi_next    = key_hi;
          next_key_next  = {1'b0, key_lo};
          found_next     = 1'b0;
          found_key_next = '0;
          state_next     = (key_lo > key_hi) ? DONE : RUN;
        end
      end
      RUN: begin
        if (hit_any) begin
          found_next     = 1'b1;
          found_key_next = hit_key;
          state_next     = DRAIN;
        end else if (!range_left) begin
          state_next = DRAIN;
        end else if (|first_free) begin
          start_vec     = first_free;
          next_key_next = next_key_reg + KEY_ONE;
        end
      end
      DRAIN: begin
        // Keys still in flight after exhaustion may yet produce the first hit.
        if (hit_any && !found_reg) begin
          found_next     = 1'b1;
          found_key_next = hit_key;
        end
        if (busy_reg == '0) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (busy_reg & ~core_done) | start_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      busy_reg      <= '0;
      next_key_reg  <= '0;
      key_hi_reg    <= '0;
      found_reg     <= 1'b0;
      found_key_reg <= '0;
    end else begin
      state_reg     <= state_next;
      busy_reg      <= busy_next;
      next_key_reg  <= next_key_next;
      key_hi_reg    <= key_hi_next;
      found_reg     <= found_next;
      found_key_reg <= found_key_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CORES; i++) core_key_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (start_vec[i]) core_key_reg[i] <= next_key_reg[KEY_W-1:0];
      end
    end
  end

  // The key is presented alongside its start pulse, then held by the register.
  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_key
      assign core_key[gi*KEY_W +: KEY_W] =
        start_vec[gi] ? next_key_reg[KEY_W-1:0] : core_key_reg[gi];
    end
  endgenerate

  assign core_start = start_vec;
  assign rdy        = (state_reg == IDLE) || (state_reg == DONE);
  assign found      = found_reg;
  assign found_key  = found_key_reg;

endmodule

// File: tb/tb_arc4_key_scheduler.sv
// Bench for arc4_key_scheduler: behavioural workers, a cycle model checked every
// cycle, and literal expectations for each directed search.
module tb_arc4_key_scheduler;
  localparam int NC = 2;
  localparam int KW = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en = 1'b0;
  logic [KW-1:0]    key_lo = '0, key_hi = '0;
  logic             rdy, found;
  logic [KW-1:0]    found_key;
  logic [NC-1:0]    core_start;
  logic [NC*KW-1:0] core_key;
  logic [NC-1:0]    core_done = '0, core_hit = '0;

  arc4_key_scheduler #(.NUM_CORES(NC), .KEY_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .key_lo(key_lo), .key_hi(key_hi), .found(found), .found_key(found_key),
    .core_start(core_start), .core_key(core_key),
    .core_done(core_done), .core_hit(core_hit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, en_cyc = 0;

  // Workers: fixed per-core latency, hit when the key falls in [hit_lo, hit_hi].
  int            w_lat [NC];
  int            w_due [NC];
  logic [KW-1:0] w_key [NC];
  logic [KW-1:0] hit_lo = '0, hit_hi = '0;
  bit            hits_on = 1'b0;

  int      log_rel [$];
  int      log_core[$];
  longint  log_key [$];

  // Model of the search, in plain integers.
  bit            m_search, m_stopped, m_found;
  longint        m_next, m_hi;
  logic [KW-1:0] m_fkey;
  logic [KW-1:0] m_key [NC];
  bit            m_busy[NC];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint lg_key(input int i);
    return (i < log_key.size()) ? log_key[i] : -1;
  endfunction

  function automatic int lg_rel(input int i);
    return (i < log_rel.size()) ? log_rel[i] : -1;
  endfunction

  function automatic int lg_core(input int i);
    return (i < log_core.size()) ? log_core[i] : -1;
  endfunction

  initial begin
    for (int i = 0; i < NC; i++) w_due[i] = -1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NC; i++) begin
        core_done[i] = (w_due[i] == cyc);
        core_hit[i]  = (w_due[i] == cyc) && hits_on && (w_key[i] >= hit_lo) && (w_key[i] <= hit_hi);
      end
    end
  end

  always @(negedge clk) begin : model
    logic [NC-1:0] exp_start, done_eff, hit_eff;
    logic [KW-1:0] hit_k;
    bit            all_idle;
    int            s;
    if (!rst_n) begin
      m_search = 0; m_stopped = 0; m_found = 0; m_fkey = '0; m_next = 0; m_hi = 0;
      for (int i = 0; i < NC; i++) begin m_busy[i] = 0; m_key[i] = '0; end
      check("reset_rdy", rdy, 1);
      check("reset_found", found, 0);
      check("reset_found_key", found_key, 0);
      check("reset_core_start", core_start, 0);
      check("reset_core_key", core_key, 0);
    end else begin
      done_eff = '0; hit_eff = '0; hit_k = '0; all_idle = 1; s = -1;
      for (int i = NC - 1; i >= 0; i--) begin
        done_eff[i] = core_done[i] && m_busy[i];
        hit_eff[i]  = done_eff[i] && core_hit[i];
        if (hit_eff[i]) hit_k = m_key[i];
        if (m_busy[i]) all_idle = 0;
        if (!m_busy[i] && !core_done[i]) s = i;
      end
      exp_start = '0;
      if (m_search && !m_stopped && hit_eff == '0 && m_next <= m_hi && s >= 0) exp_start[s] = 1'b1;

      check("rdy", rdy, !m_search);
      check("found", found, m_found);
      check("found_key", found_key, m_fkey);
      check("core_start", core_start, exp_start);
      for (int i = 0; i < NC; i++)
        check("core_key", core_key[i*KW +: KW], exp_start[i] ? m_next[KW-1:0] : m_key[i]);

      for (int i = 0; i < NC; i++) begin
        if (core_start[i] === 1'b1) begin
          w_key[i] = core_key[i*KW +: KW];
          w_due[i] = cyc + w_lat[i];
          log_rel.push_back(cyc - en_cyc);
          log_core.push_back(i);
          log_key.push_back(longint'(core_key[i*KW +: KW]));
        end
      end

      if (!m_search) begin
        if (en) begin
          m_found = 0; m_fkey = '0;
          if (key_lo <= key_hi) begin
            m_search = 1; m_stopped = 0; m_next = longint'(key_lo); m_hi = longint'(key_hi);
          end
        end
      end else if (!m_stopped) begin
        if (hit_eff != '0) begin
          m_found = 1; m_fkey = hit_k; m_stopped = 1;
        end else if (m_next > m_hi) begin
          m_stopped = 1;
        end
      end else begin
        if (hit_eff != '0 && !m_found) begin m_found = 1; m_fkey = hit_k; end
        if (all_idle) m_search = 0;
      end
      for (int i = 0; i < NC; i++) begin
        if (done_eff[i]) m_busy[i] = 0;
        if (exp_start[i]) begin m_busy[i] = 1; m_key[i] = m_next[KW-1:0]; end
      end
      if (exp_start != '0) m_next = m_next + 1;
    end
  end

  task automatic wait_rdy(input string nm);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rdy === 1'b1) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL %s: rdy timeout got 0 want 1", nm);
  endtask

  task automatic start_search(input logic [KW-1:0] lo, input logic [KW-1:0] hi);
    wait_rdy("pre_start");
    @(posedge clk); #1;
    key_lo = lo; key_hi = hi; en = 1'b1; en_cyc = cyc;
    log_rel.delete(); log_core.delete(); log_key.delete();
    @(posedge clk); #1;
    en = 1'b0;
    key_lo = ~lo; key_hi = ~hi;   // later changes must not matter
  endtask

  task automatic report(input logic [KW-1:0] lo, input logic [KW-1:0] hi);
    $display("search lo=%06h hi=%06h starts=%0d found=%0d key=%06h",
             lo, hi, log_key.size(), found, found_key);
  endtask

  initial begin
    rst_n = 1'b1;
    w_lat[0] = 10; w_lat[1] = 10;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hit at key 5: starts at 1 and 2, six starts total, none after the hit.
    hits_on = 1; hit_lo = 24'h5; hit_hi = 24'h5;
    start_search(24'h0, 24'hF);
    wait_rdy("t1_done");
    check("t1_first_rel", lg_rel(0), 1);
    check("t1_first_core", lg_core(0), 0);
    check("t1_first_key", lg_key(0), 0);
    check("t1_second_rel", lg_rel(1), 2);
    check("t1_second_core", lg_core(1), 1);
    check("t1_second_key", lg_key(1), 1);
    check("t1_starts", log_key.size(), 6);
    check("t1_last_rel", lg_rel(5), 24);
    check("t1_found", found, 1);
    check("t1_found_key", found_key, 24'h5);
    report(24'h0, 24'hF);

    // No hits, four keys.
    hits_on = 0;
    start_search(24'h10, 24'h13);
    wait_rdy("t2_done");
    check("t2_starts", log_key.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_key", lg_key(i), 24'h10 + i);
    check("t2_found", found, 0);
    check("t2_found_key", found_key, 0);
    report(24'h10, 24'h13);

    // Top of the key space: no wrap.
    start_search(24'hFFFFFE, 24'hFFFFFF);
    wait_rdy("t3_done");
    check("t3_starts", log_key.size(), 2);
    check("t3_key0", lg_key(0), 24'hFFFFFE);
    check("t3_key1", lg_key(1), 24'hFFFFFF);
    check("t3_found", found, 0);
    report(24'hFFFFFE, 24'hFFFFFF);

    // Simultaneous hits on both cores: lowest index wins.
    w_lat[0] = 11; w_lat[1] = 10;
    hits_on = 1; hit_lo = 24'h8; hit_hi = 24'h9;
    start_search(24'h8, 24'hF);
    wait_rdy("t5a_done");
    check("t5a_starts", log_key.size(), 2);
    check("t5a_found", found, 1);
    check("t5a_found_key", found_key, 24'h8);
    report(24'h8, 24'hF);

    // Empty range right after a hit: found must clear.
    start_search(24'h20, 24'h1F);
    @(negedge clk);
    check("t4_rdy", rdy, 1);
    check("t4_found", found, 0);
    check("t4_starts", log_key.size(), 0);
    report(24'h20, 24'h1F);

    // Later hit from the draining core is ignored.
    w_lat[0] = 10; w_lat[1] = 12;
    start_search(24'h8, 24'hF);
    wait_rdy("t5b_done");
    check("t5b_starts", log_key.size(), 2);
    check("t5b_found_key", found_key, 24'h8);
    report(24'h8, 24'hF);

    // Reset with both cores busy, stale dones land while idle, then a fresh run.
    w_lat[0] = 10; w_lat[1] = 10;
    hits_on = 0;
    start_search(24'h30, 24'h3F);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_rdy", rdy, 1);
    check("rst_core_start", core_start, 0);
    check("rst_found", found, 0);
    check("rst_core_key", core_key, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    report(24'h30, 24'h3F);
    repeat (8) @(posedge clk);
    hits_on = 1; hit_lo = 24'h41; hit_hi = 24'h41;
    start_search(24'h40, 24'h41);
    wait_rdy("t6_done");
    check("t6_starts", log_key.size(), 2);
    check("t6_key0", lg_key(0), 24'h40);
    check("t6_found", found, 1);
    check("t6_found_key", found_key, 24'h41);
    report(24'h40, 24'h41);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/arc4_key_scheduler.md
Name: arc4_key_scheduler

Overview:
- Dispatches ARC4 key candidates across NUM_CORES independent decrypt workers for the key-cracking flow.
- Each worker is an init/KSA/PRGA pipeline plus a plaintext checker, with a start/done handshake.
- The block walks an inclusive key range, starts idle workers one per cycle, and collects hit reports.
- It stops on the first hit and reports the winning key, or reports "not found" once the range is exhausted and all workers have drained.

Parameters:
- NUM_CORES, default 4: number of worker cores; legal range 1..16.
- KEY_W, default 24: key width in bits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  start request; sampled only when rdy=1.
- rdy  output  1  high when idle or done; low while a search is running.
- key_lo  input  KEY_W  first key of the range, inclusive; latched on accepted en.
- key_hi  input  KEY_W  last key of the range, inclusive; latched on accepted en.
- found  output  1  valid while rdy=1 after a search; 1 means a key hit.
- found_key  output  KEY_W  winning key; valid when found=1, otherwise 0.
- core_start  output  NUM_CORES  one-cycle start pulse per core.
- core_key  output  NUM_CORES*KEY_W  key per core; slice i belongs to core i and is held stable from start until that core's done.
- core_done  input  NUM_CORES  one-cycle completion pulse per core.
- core_hit  input  NUM_CORES  qualifies core_done; 1 means the plaintext check passed.

Behaviour:
- Reset values: rdy=1, found=0, found_key=0, core_start=0, core_key=0. Internal state: state=IDLE, busy mask=0, key counter=0.
- Reset mid-search aborts immediately. Any worker pulses arriving after reset are ignored.
- Key counter is KEY_W+1 bits wide, so key_hi = all-ones terminates without wrapping back to 0.
- IDLE:
  - rdy=1.
  - Accepted en latches key_lo/key_hi, sets next_key=key_lo, clears found/found_key, and moves to RUN.
  - If key_lo > key_hi, go straight to DONE with found=0.
- RUN:
  - Each cycle, while next_key <= key_hi, the block picks the lowest-index core with busy=0 and done-this-cycle=0.
  - For that core it drives core_key[i]=next_key, pulses core_start[i] for one cycle, sets busy[i], and increments next_key.
  - At most one start per cycle.
  - The first core_start occurs the cycle after en is accepted.
- Done handling:
  - core_done[i] clears busy[i]. Core i is eligible for restart no earlier than the following cycle.
  - A core_done on a core with busy=0 is ignored.
- Hit capture:
  - The first core_done with core_hit=1 latches found=1 and found_key=core_key[i].
  - If several cores report hits in the same cycle, the lowest index wins.
  - Dispatch stops that same cycle, with no core_start in that cycle, and state moves to DRAIN.
- Exhaustion: when next_key > key_hi, state moves to DRAIN.
- DRAIN:
  - No starts.
  - Waits until busy mask = 0, then goes to DONE.
  - Hits arriving in DRAIN are ignored if found is already 1.
  - Hits are accepted as first hit if found=0, i.e. a range exhausted with in-flight keys.
- DONE:
  - rdy=1. found and found_key are held.
  - Accepted en restarts as in IDLE, clearing found the next cycle.
- en while rdy=0 is ignored.
- key_lo/key_hi changes during a search have no effect.
- A core_done and a core_start in the same cycle on different cores are both legal.

Test Plan:
- NUM_CORES=2; behavioural workers with 10-cycle latency, hit at key 0x000005; key_lo=0, key_hi=0x0F. Required: starts at cycles 1 (key 0 to core0) and 2 (key 1 to core1). Then rdy=1, found=1, found_key=0x000005, and no starts after the hit cycle.
- key_lo=0x10, key_hi=0x13, no hits. Required: exactly 4 core_start pulses with keys 0x10..0x13, then DONE with found=0 and found_key=0 after the last done.
- key_lo=0xFFFFFE, key_hi=0xFFFFFF. Required: exactly 2 starts (0xFFFFFE, 0xFFFFFF), no wrap to 0x000000, then done.
- key_lo=0x20, key_hi=0x1F. Required: no core_start, and rdy returns with found=0 within 2 cycles.
- Both cores pulse core_done with hit in the same cycle (core0 key 0x08, core1 key 0x09). Required: found_key=0x08, and the later hit from the draining core is ignored.
- Assert rst_n=0 mid-RUN with 2 cores busy. Required: rdy=1, core_start=0, found=0 immediately. A subsequent en with a fresh range runs normally, and stale core_done pulses are ignored.
